dual_port_mem_ctl: RTL

- Parametrised successor to the team's single-port 32-bit memory.
- Provides one read/write port (A, with byte enables) and one read-only port (B) over a shared array.
- Adds a configurable read latency, a read-during-write mode, an out-of-range address check, and a hardware zero-fill sweep after reset.
- Sits between datapath blocks and local storage; consumers gate requests on ready.

---
 rtl/dual_port_mem_ctl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dual_port_mem_ctl.sv
// rtl/dual_port_mem_ctl.sv - dual-port memory: port A read/write with byte enables, port B read-only.
// The array is zero-filled after reset, and requests are ignored until ready.
module dual_port_mem_ctl #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ready,
   input  logic                en_a,
   input  logic                we_a,
   input  logic [DATA_W/8-1:0] be_a,
   input  logic [ADDR_W-1:0]   addr_a,
   input  logic [DATA_W-1:0]   din_a,
   output logic [DATA_W-1:0]   dout_a,
   output logic                vld_a,
   input  logic                en_b,
   input  logic [ADDR_W-1:0]   addr_b,
   output logic [DATA_W-1:0]   dout_b,
   output logic                vld_b,
   output logic                err
);
   localparam int              LP_BYTES = DATA_W / 8;
   localparam int              LP_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [LP_IDX_W-1:0] LP_LAST = LP_IDX_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LP_IDX_W-1:0]   r_cnt;
   logic [DATA_W-1:0]     r_mem [DEPTH];

   logic                  w_rdy;
   logic                  w_in_a;
   logic                  w_in_b;
   logic [LP_IDX_W-1:0]   w_idx_a;
   logic [LP_IDX_W-1:0]   w_idx_b;
   logic                  w_wr_a;
   logic                  w_rd_a;
   logic                  w_rd_b;
   logic                  w_oor;
   logic                  w_coll;
   logic [DATA_W-1:0]     w_old_a;
   logic [DATA_W-1:0]     w_merged;
   logic [DATA_W-1:0]     w_rd_dat_a;
   logic [DATA_W-1:0]     w_rd_dat_b;

   // Stage 0 captures the read at the request edge; stage RD_LAT drives the outputs.
   logic                  r_pv_a [RD_LAT+1];
   logic                  r_pv_b [RD_LAT+1];
   logic [DATA_W-1:0]     r_pd_a [RD_LAT+1];
   logic [DATA_W-1:0]     r_pd_b [RD_LAT+1];
   logic                  r_oor;
   logic                  r_err;

   assign w_rdy   = (r_state == ST_READY);
   assign w_in_a  = ({1'b0, addr_a} < LP_DEPTH);
   assign w_in_b  = ({1'b0, addr_b} < LP_DEPTH);
   assign w_idx_a = addr_a[LP_IDX_W-1:0];
   assign w_idx_b = addr_b[LP_IDX_W-1:0];
   assign w_wr_a  = w_rdy & en_a & we_a & w_in_a;
   assign w_rd_a  = w_rdy & en_a & ~we_a;
   assign w_rd_b  = w_rdy & en_b;
   assign w_oor   = w_rdy & ((en_a & ~w_in_a) | (en_b & ~w_in_b));
   assign w_coll  = w_wr_a & (addr_a == addr_b);

   always_comb begin
      w_old_a  = r_mem[w_idx_a];
      w_merged = w_old_a;
      for (int i = 0; i < LP_BYTES; i++) begin
         if (be_a[i]) begin
            w_merged[8*i +: 8] = din_a[8*i +: 8];
         end
      end
   end

   assign w_rd_dat_a = w_in_a ? w_old_a : '0;
   assign w_rd_dat_b = !w_in_b ? '0 :
                       ((RDW_MODE != 0) && w_coll) ? w_merged : r_mem[w_idx_b];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:  if (r_cnt == LP_LAST) w_state_nxt = ST_READY;
         ST_READY: w_state_nxt = ST_READY;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) r_cnt <= r_cnt + LP_IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
         end else if (w_wr_a) begin
            r_mem[w_idx_a] <= w_merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k <= RD_LAT; k++) begin
            r_pv_a[k] <= 1'b0;
            r_pv_b[k] <= 1'b0;
            r_pd_a[k] <= '0;
            r_pd_b[k] <= '0;
         end
         r_oor <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_pv_a[0] <= w_rd_a;
         r_pv_b[0] <= w_rd_b;
         if (w_rd_a) r_pd_a[0] <= w_rd_dat_a;
         if (w_rd_b) r_pd_b[0] <= w_rd_dat_b;
         for (int k = 1; k <= RD_LAT; k++) begin
            r_pv_a[k] <= r_pv_a[k-1];
            r_pv_b[k] <= r_pv_b[k-1];
            if (r_pv_a[k-1]) r_pd_a[k] <= r_pd_a[k-1];
            if (r_pv_b[k-1]) r_pd_b[k] <= r_pd_b[k-1];
         end
         r_oor <= w_oor;
         r_err <= r_oor;
      end
   end

   assign ready  = w_rdy;
   assign vld_a  = r_pv_a[RD_LAT];
   assign vld_b  = r_pv_b[RD_LAT];
   assign dout_a = r_pd_a[RD_LAT];
   assign dout_b = r_pd_b[RD_LAT];
   assign err    = r_err;

endmodule
